// File: rtl/bcd_seg_if.sv
// Request/result handshake between the display block (master) and the binary-to-BCD converter (slave).
interface bcd_seg_if;
  logic [15:0] bcd;
  logic        rdy;
  logic        conv_en;

  modport master (output conv_en, input bcd, input rdy);
  modport slave  (input conv_en, output bcd, output rdy);
endinterface

// File: rtl/bcd_seg_display.sv
// Periodically requests a BCD conversion, captures the result and scans it onto a 4-digit 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module bcd_seg_display #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned REQ_DIV    = 10000000,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_seg_if.master        cv,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an,
  output logic             stale
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned REQ_W  = (REQ_DIV > 1) ? $clog2(REQ_DIV) : 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic        POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [6:0]  SEG_OFF = POL_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]  AN_OFF  = POL_LOW ? 4'hF : 4'h0;
  localparam logic        DP_OFF  = POL_LOW;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e              state_q, state_d;
  logic [REQ_W-1:0]    req_cnt_q, req_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]          digit_sel_q, digit_sel_d;
  logic [15:0]         disp_q, disp_d;
  logic                conv_en_q, conv_en_d;
  logic                stale_q, stale_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          an_q, an_d;
  logic                dp_q, dp_d;

  logic                req_tc;
  logic                scan_tc;
  logic [3:0]          cur_nib;
  logic [3:0]          lead_zero;
  logic [6:0]          seg_on;
  logic [3:0]          an_on;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  endfunction

  assign req_tc  = (req_cnt_q == REQ_W'(REQ_DIV - 1));
  assign scan_tc = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign cur_nib = disp_q[{digit_sel_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every more significant digit are zero; units never blank.
  always_comb begin
    lead_zero = 4'b0000;
`ifdef SEG_LZB_EN
    lead_zero[3] = (disp_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
`endif
  end

  assign seg_on = lead_zero[digit_sel_q] ? 7'h00 : glyph(cur_nib);
  assign an_on  = 4'b0001 << digit_sel_q;

  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_tc ? '0 : req_cnt_q + 1'b1;
    wait_cnt_d  = wait_cnt_q;
    conv_en_d   = 1'b0;
    stale_d     = stale_q;
    disp_d      = disp_q;
    scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + 1'b1;
    digit_sel_d = digit_sel_q;
    seg_d       = seg_q;
    an_d        = an_q;
    dp_d        = DP_OFF;

    // rdy in the request cycle itself cannot be a genuine answer, so it is masked by conv_en_q.
    case (state_q)
      ST_IDLE: begin
        if (req_tc) begin
          conv_en_d  = 1'b1;
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (cv.rdy && !conv_en_q) begin
          disp_d  = cv.bcd;
          stale_d = 1'b0;
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          stale_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Anode and segments change together at the slot boundary.
    if (scan_tc) begin
      digit_sel_d = digit_sel_q + 2'd1;
      seg_d       = POL_LOW ? ~seg_on : seg_on;
      an_d        = POL_LOW ? ~an_on : an_on;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      conv_en_q   <= 1'b0;
      stale_q     <= 1'b0;
      disp_q      <= 16'h0000;
      scan_cnt_q  <= '0;
      digit_sel_q <= 2'd0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      dp_q        <= DP_OFF;
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      conv_en_q   <= conv_en_d;
      stale_q     <= stale_d;
      disp_q      <= disp_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign cv.conv_en = conv_en_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign stale      = stale_q;

endmodule
